// File: rtl/muldiv_unit_pkg.sv
// Shared ALU/muldiv definitions used by the decoder and the multiply/divide unit.
// Contents: datapath width XLEN, ALU select width and codes, the muldiv FSM
// state type, and small decode helpers for the RV32M subset.
package muldiv_unit_pkg;

    localparam int XLEN      = 32;
    localparam int ALU_SEL_W = 5;

    // Base integer ALU operations
    localparam logic [ALU_SEL_W-1:0] ALU_ADD    = 5'd0;
    localparam logic [ALU_SEL_W-1:0] ALU_SUB    = 5'd1;
    localparam logic [ALU_SEL_W-1:0] ALU_SLL    = 5'd2;
    localparam logic [ALU_SEL_W-1:0] ALU_SLT    = 5'd3;
    localparam logic [ALU_SEL_W-1:0] ALU_SLTU   = 5'd4;
    localparam logic [ALU_SEL_W-1:0] ALU_XOR    = 5'd5;
    localparam logic [ALU_SEL_W-1:0] ALU_SRL    = 5'd6;
    localparam logic [ALU_SEL_W-1:0] ALU_SRA    = 5'd7;
    localparam logic [ALU_SEL_W-1:0] ALU_OR     = 5'd8;
    localparam logic [ALU_SEL_W-1:0] ALU_AND    = 5'd9;
    // RV32M operations
    localparam logic [ALU_SEL_W-1:0] ALU_MUL    = 5'd16;
    localparam logic [ALU_SEL_W-1:0] ALU_MULH   = 5'd17;
    localparam logic [ALU_SEL_W-1:0] ALU_MULHSU = 5'd18;
    localparam logic [ALU_SEL_W-1:0] ALU_MULHU  = 5'd19;
    localparam logic [ALU_SEL_W-1:0] ALU_DIV    = 5'd20;
    localparam logic [ALU_SEL_W-1:0] ALU_DIVU   = 5'd21;
    localparam logic [ALU_SEL_W-1:0] ALU_REM    = 5'd22;
    localparam logic [ALU_SEL_W-1:0] ALU_REMU   = 5'd23;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } muldiv_state_t;

    // True for any of the eight RV32M select codes.
    function automatic logic is_muldiv(input logic [ALU_SEL_W-1:0] sel);
        logic hit;
        case (sel)
            ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: hit = 1'b1;
            default:                              hit = 1'b0;
        endcase
        return hit;
    endfunction

    // True for the multiply group (shift-add datapath).
    function automatic logic is_mul_op(input logic [ALU_SEL_W-1:0] sel);
        logic hit;
        case (sel)
            ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU: hit = 1'b1;
            default:                                  hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negator.
// Ports: value_i (W) operand, neg_i (1) negate when high, value_o (W) result.
module muldiv_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] value_i,
    input  logic         neg_i,
    output logic [W-1:0] value_o
);

    assign value_o = neg_i ? (~value_i + {{(W-1){1'b0}}, 1'b1}) : value_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle over 32 CALC cycles,
// then a single FIX cycle for sign correction and result selection.
// Ports: clk, rst_n (sync active-low), start, flush, alu_ctl, src_a, src_b in;
//        busy (state != IDLE), done (1-cycle pulse), result (held) out.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = muldiv_unit_pkg::XLEN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 flush,
    input  logic [ALU_SEL_W-1:0] alu_ctl,
    input  logic [XLEN-1:0]      src_a,
    input  logic [XLEN-1:0]      src_b,
    output logic                 busy,
    output logic                 done,
    output logic [XLEN-1:0]      result
);

    localparam logic [5:0]      CNT_LAST = 6'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};

    muldiv_state_t          state_q, state_d;
    logic [ALU_SEL_W-1:0]   op_q;
    logic                   sa_q, sb_q, spec_q;
    logic [XLEN-1:0]        a_q, b_q, quot_q, spec_res_q, result_q;
    logic [2*XLEN-1:0]      prod_q;
    logic [XLEN:0]          rem_q;
    logic [5:0]             cnt_q;

    logic                   sa_s, sb_s, is_div_s, div_zero_s, ovf_s, fast_s, accept_s;
    logic [XLEN-1:0]        a_mag_s, b_mag_s, spec_res_s, fix_res_s;
    logic [XLEN:0]          mul_sum_s;
    logic [XLEN+1:0]        div_shift_s, div_diff_s;
    logic                   div_ge_s;
    logic [2*XLEN-1:0]      prod_fix_s;
    logic [XLEN-1:0]        quot_fix_s, rem_fix_s;

    // Operand sign extraction: only signed operand positions contribute a sign.
    always_comb begin
        sa_s = 1'b0;
        sb_s = 1'b0;
        case (alu_ctl)
            ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM: begin
                sa_s = src_a[XLEN-1];
                sb_s = src_b[XLEN-1];
            end
            ALU_MULHSU: begin
                sa_s = src_a[XLEN-1];
                sb_s = 1'b0;
            end
            default: begin
                sa_s = 1'b0;
                sb_s = 1'b0;
            end
        endcase
    end

    muldiv_negate #(.W(XLEN)) u_neg_a (.value_i(src_a), .neg_i(sa_s), .value_o(a_mag_s));
    muldiv_negate #(.W(XLEN)) u_neg_b (.value_i(src_b), .neg_i(sb_s), .value_o(b_mag_s));

    // Fast-path detection (divide by zero, signed overflow) and their fixed results.
    always_comb begin
        is_div_s   = (alu_ctl == ALU_DIV) || (alu_ctl == ALU_DIVU) ||
                     (alu_ctl == ALU_REM) || (alu_ctl == ALU_REMU);
        div_zero_s = is_div_s && (src_b == ZERO);
        ovf_s      = ((alu_ctl == ALU_DIV) || (alu_ctl == ALU_REM)) &&
                     (src_a == INT_MIN) && (src_b == ALL_ONES);
        fast_s     = div_zero_s || ovf_s;
        if (div_zero_s) begin
            spec_res_s = ((alu_ctl == ALU_DIV) || (alu_ctl == ALU_DIVU)) ? ALL_ONES : src_a;
        end else if (ovf_s) begin
            spec_res_s = (alu_ctl == ALU_DIV) ? INT_MIN : ZERO;
        end else begin
            spec_res_s = ZERO;
        end
        accept_s = (state_q == MD_IDLE) && start && is_muldiv(alu_ctl) && !flush;
    end

    // Per-iteration arithmetic: one conditional add (multiply) or trial subtract (divide).
    always_comb begin
        mul_sum_s   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_q} : {1'b0, ZERO});
        div_shift_s = {rem_q, quot_q[XLEN-1]};
        div_diff_s  = div_shift_s - {2'b00, b_q};
        // No borrow out of the trial subtract means the divisor fits.
        div_ge_s    = ~div_diff_s[XLEN+1];
    end

    muldiv_negate #(.W(2*XLEN)) u_neg_prod (.value_i(prod_q), .neg_i(sa_q ^ sb_q), .value_o(prod_fix_s));
    muldiv_negate #(.W(XLEN)) u_neg_quot (.value_i(quot_q), .neg_i(sa_q ^ sb_q), .value_o(quot_fix_s));
    muldiv_negate #(.W(XLEN)) u_neg_rem (.value_i(rem_q[XLEN-1:0]), .neg_i(sa_q), .value_o(rem_fix_s));

    // Result selection applied in the FIX cycle.
    always_comb begin
        if (spec_q) begin
            fix_res_s = spec_res_q;
        end else begin
            case (op_q)
                ALU_MUL:                          fix_res_s = prod_fix_s[XLEN-1:0];
                ALU_MULH, ALU_MULHSU, ALU_MULHU:  fix_res_s = prod_fix_s[2*XLEN-1:XLEN];
                ALU_DIV, ALU_DIVU:                fix_res_s = quot_fix_s;
                ALU_REM, ALU_REMU:                fix_res_s = rem_fix_s;
                default:                          fix_res_s = ZERO;
            endcase
        end
    end

    // Next-state logic; flush overrides everything, including a same-cycle start.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = MD_IDLE;
        end else begin
            case (state_q)
                MD_IDLE: state_d = accept_s ? (fast_s ? MD_FIX : MD_CALC) : MD_IDLE;
                MD_CALC: state_d = (cnt_q == CNT_LAST) ? MD_FIX : MD_CALC;
                MD_FIX:  state_d = MD_DONE;
                MD_DONE: state_d = MD_IDLE;
                default: state_d = MD_IDLE;
            endcase
        end
    end

    // State register and datapath.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= MD_IDLE;
            op_q       <= {ALU_SEL_W{1'b0}};
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            spec_q     <= 1'b0;
            a_q        <= ZERO;
            b_q        <= ZERO;
            quot_q     <= ZERO;
            spec_res_q <= ZERO;
            result_q   <= ZERO;
            prod_q     <= {(2*XLEN){1'b0}};
            rem_q      <= {(XLEN+1){1'b0}};
            cnt_q      <= 6'd0;
        end else begin
            state_q <= state_d;
            if (accept_s) begin
                op_q       <= alu_ctl;
                sa_q       <= sa_s;
                sb_q       <= sb_s;
                spec_q     <= fast_s;
                spec_res_q <= spec_res_s;
                a_q        <= a_mag_s;
                b_q        <= b_mag_s;
                prod_q     <= {ZERO, b_mag_s};
                quot_q     <= a_mag_s;
                rem_q      <= {(XLEN+1){1'b0}};
                cnt_q      <= 6'd0;
            end else if ((state_q == MD_CALC) && !flush) begin
                if (is_mul_op(op_q)) begin
                    prod_q <= {mul_sum_s, prod_q[XLEN-1:1]};
                end else begin
                    rem_q  <= div_ge_s ? div_diff_s[XLEN:0] : div_shift_s[XLEN:0];
                    quot_q <= {quot_q[XLEN-2:0], div_ge_s};
                end
                // Saturate at the last iteration so the counter never wraps.
                if (cnt_q != CNT_LAST) begin
                    cnt_q <= cnt_q + 6'd1;
                end
            end
            if ((state_q == MD_FIX) && !flush) begin
                result_q <= fix_res_s;
            end
        end
    end

    // Output decode from registered state.
    always_comb begin
        busy   = (state_q != MD_IDLE);
        done   = (state_q == MD_DONE);
        result = result_q;
    end

endmodule
